fetch_unit: RTL

Instruction-fetch stage of the single-issue RISC-V core. Holds the program counter, drives the word address into the instruction memory and captures the returned word the same cycle. Buffers fetched instructions in a small in-order queue that feeds decode (control unit, register file, immediate extender) through a valid/ready handshake. Accepts branch/jump redirects that flush the queue and reload the PC.

---
 rtl/fetch_unit.sv | 117 +++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Holds the PC, reads the instruction
// memory combinationally and buffers {pc, instr} pairs in a DEPTH-entry
// in-order queue that feeds decode over a valid/ready handshake. Redirects
// flush the queue and reload the PC.
//
// Optional feature macro: FETCH_MISALIGN_CHECK_EN
//   defined   : a redirect to a non-word-aligned target raises a sticky
//               fetch_fault, loads the raw target and stops all fetching.
//   undefined : target[1:0] is ignored and fetch_fault is tied to 0.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   imem_addr           byte address to instruction memory (the PC register)
//   imem_rdata          instruction word for imem_addr, same cycle
//   id_valid/id_ready   decode handshake on the queue head
//   id_instr, id_pc,    head entry and its pc + 4; all zero when id_valid=0
//   id_pc_plus4
//   redirect_valid,     flush the queue and reload the PC with the target
//   redirect_target
//   fetch_fault         sticky misaligned-redirect fault
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        fetch_fault
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [31:0]      r_pc;
    logic [31:0]      r_q_pc    [DEPTH];
    logic [31:0]      r_q_instr [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_fault;

    logic             w_pop;
    logic             w_push;
    logic             w_full;
    logic [31:0]      w_redir_pc;
    logic             w_misalign;

    // Redirect target handling depends on whether misalignment is trapped
`ifdef FETCH_MISALIGN_CHECK_EN
    assign w_redir_pc = redirect_target;
    assign w_misalign = redirect_valid & (redirect_target[1:0] != 2'b00);
`else
    assign w_redir_pc = {redirect_target[31:2], 2'b00};
    assign w_misalign = 1'b0;
`endif

    assign w_full   = (r_count == CNT_W'(DEPTH));
    assign id_valid = (r_count != '0);
    assign w_pop    = id_valid & id_ready;
    // A full queue can still accept a fetch when the head leaves this cycle
    assign w_push   = ~redirect_valid & ~r_fault & (~w_full | w_pop);

    assign imem_addr   = r_pc;
    assign fetch_fault = r_fault;

    // Head is presented straight from the queue slot
    assign id_instr    = id_valid ? r_q_instr[r_rd_ptr] : 32'h0;
    assign id_pc       = id_valid ? r_q_pc[r_rd_ptr]    : 32'h0;
    assign id_pc_plus4 = id_valid ? (r_q_pc[r_rd_ptr] + 32'd4) : 32'h0;

    // Control state: PC, pointers, occupancy, fault
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc     <= RESET_PC;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_fault  <= 1'b0;
        end else if (redirect_valid) begin
            r_pc     <= w_redir_pc;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_fault  <= r_fault | w_misalign;
        end else begin
            if (w_push) begin
                r_pc     <= r_pc + 32'd4;
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Queue payload storage; validity is tracked by r_count alone
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_q_pc[r_wr_ptr]    <= r_pc;
            r_q_instr[r_wr_ptr] <= imem_rdata;
        end
    end

endmodule
